// File: rtl/rgbled_pkg.sv
// rgbled_pkg: shared state encoding, colour type and default WS281x timing.
package rgbled_pkg;
   typedef enum logic [1:0] {IDLE, SEND_HIGH, SEND_LOW, LATCH} state_e;
   typedef logic [23:0] color_t;
   localparam int DefT0HCycles = 20;
   localparam int DefT1HCycles = 40;
   localparam int DefBitCycles = 63;
   localparam int DefResetCycles = 4000;
   // WS281x expects green first: reorder {R,G,B} into transmit order {G,R,B}.
   function automatic color_t to_grb(color_t c);
      return {c[15:8], c[23:16], c[7:0]};
   endfunction
endpackage

// File: rtl/ws281x_bit_enc.sv
// ws281x_bit_enc: times one WS281x bit; high phase by bit value, fixed period.
module ws281x_bit_enc
   import rgbled_pkg::*;
#(
   parameter int T0HCycles = DefT0HCycles,
   parameter int T1HCycles = DefT1HCycles,
   parameter int BitCycles = DefBitCycles,
   parameter int CntW = $clog2(BitCycles + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic bit_i,
   output logic dout_o,
   output logic done_o
);
   logic [CntW-1:0] cnt_q;
   logic            busy_q;
   logic            bit_q;
   logic            dout_q;
   logic [CntW-1:0] high_len;

   assign high_len = bit_q ? CntW'(T1HCycles) : CntW'(T0HCycles);
   assign done_o   = busy_q && cnt_q == CntW'(BitCycles);
   assign dout_o   = dout_q;

   // cnt_q is the 1-based cycle number within the bit; a start on the last cycle chains bits gap-free.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         bit_q  <= 1'b0;
         dout_q <= 1'b0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= CntW'(1);
         bit_q  <= bit_i;
         dout_q <= 1'b1;
      end else if (done_o) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         dout_q <= 1'b0;
      end else if (busy_q) begin
         cnt_q  <= cnt_q + CntW'(1);
         dout_q <= cnt_q < high_len;
      end
   end
endmodule

// File: rtl/rgbled_chain_ctrl.sv
// rgbled_chain_ctrl: double-buffered WS281x daisy-chain frame sequencer.
module rgbled_chain_ctrl
   import rgbled_pkg::*;
#(
   parameter int NumLeds = 2,
   parameter int T0HCycles = DefT0HCycles,
   parameter int T1HCycles = DefT1HCycles,
   parameter int BitCycles = DefBitCycles,
   parameter int ResetCycles = DefResetCycles,
   localparam int IdxW = NumLeds > 1 ? $clog2(NumLeds) : 1,
   localparam int CntW = $clog2((BitCycles > ResetCycles ? BitCycles : ResetCycles) + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wr_en_i,
   input  logic [IdxW-1:0] wr_idx_i,
   input  logic [23:0]     wr_data_i,
   input  logic            go_i,
   input  logic            continuous_i,
   output logic            idle_o,
   output logic            frame_done_o,
   output logic            dout_o
);
   color_t          wbuf_q [NumLeds];
   color_t          dbuf_q [NumLeds];
   state_e          state_q;
   logic [IdxW-1:0] led_q;
   logic [4:0]      bit_q;
   logic [CntW-1:0] lcnt_q;
   logic            idle_q;
   logic            done_q;
   logic            wr_ok, sending, last_bit, launch, enc_start, enc_bit, enc_dout, enc_done;
   logic [IdxW-1:0] led_n;
   logic [4:0]      bit_n;
   color_t          cur;

   // Next-bit selection; a frame launch takes G[7] of LED 0 straight from the write buffer being copied.
   always_comb begin
      wr_ok     = wr_en_i && int'(wr_idx_i) < NumLeds;
      sending   = state_q == SEND_HIGH || state_q == SEND_LOW;
      last_bit  = led_q == IdxW'(NumLeds - 1) && bit_q == 5'd0;
      launch    = (state_q == IDLE && go_i) ||
                  (state_q == LATCH && lcnt_q == CntW'(ResetCycles) && continuous_i);
      led_n     = bit_q == 5'd0 ? led_q + 1'b1 : led_q;
      bit_n     = bit_q == 5'd0 ? 5'd23 : bit_q - 5'd1;
      cur       = to_grb(dbuf_q[led_n]);
      enc_start = launch || (sending && enc_done && !last_bit);
      enc_bit   = launch ? wbuf_q[0][15] : cur[bit_n];
   end

   ws281x_bit_enc #(
      .T0HCycles(T0HCycles),
      .T1HCycles(T1HCycles),
      .BitCycles(BitCycles),
      .CntW     (CntW)
   ) u_enc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(enc_start),
      .bit_i  (enc_bit),
      .dout_o (enc_dout),
      .done_o (enc_done)
   );

   // Buffers and frame FSM; bit_q counts down through the 24 GRB positions of LED led_q.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         led_q   <= '0;
         bit_q   <= '0;
         lcnt_q  <= '0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         for (int i = 0; i < NumLeds; i++) begin
            wbuf_q[i] <= '0;
            dbuf_q[i] <= '0;
         end
      end else begin
         if (wr_ok) wbuf_q[wr_idx_i] <= wr_data_i;
         if (launch) for (int i = 0; i < NumLeds; i++) dbuf_q[i] <= wbuf_q[i];
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (launch) begin
               state_q <= SEND_HIGH;
               led_q   <= '0;
               bit_q   <= 5'd23;
               idle_q  <= 1'b0;
            end
            SEND_HIGH, SEND_LOW: begin
               if (enc_done && last_bit) begin
                  state_q <= LATCH;
                  lcnt_q  <= CntW'(1);
                  done_q  <= ResetCycles == 1;
               end else if (enc_done) begin
                  state_q <= SEND_HIGH;
                  led_q   <= led_n;
                  bit_q   <= bit_n;
               end else if (state_q == SEND_HIGH && !enc_dout) begin
                  state_q <= SEND_LOW;
               end
            end
            LATCH: begin
               lcnt_q <= lcnt_q + CntW'(1);
               done_q <= lcnt_q == CntW'(ResetCycles - 1);
               if (lcnt_q == CntW'(ResetCycles)) begin
                  lcnt_q  <= '0;
                  done_q  <= 1'b0;
                  state_q <= launch ? SEND_HIGH : IDLE;
                  idle_q  <= !launch;
                  led_q   <= '0;
                  bit_q   <= launch ? 5'd23 : 5'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idle_o       = idle_q;
   assign frame_done_o = done_q;
   assign dout_o       = enc_dout;
endmodule

// File: tb/tb_rgbled_chain_ctrl.sv
// tb_rgbled_chain_ctrl: decodes dout_o bit by bit against a queue of expected bits.
module tb_rgbled_chain_ctrl;
   localparam int B = 63, T0 = 20, T1 = 40, R = 4000;
   typedef struct {logic [23:0] rgb; logic [23:0] grb;} vec_t;

   logic        clk = 0, rst = 1, wr_en = 0, go = 0, cont = 0;
   logic [1:0]  wr_idx = 0, sel = 0;
   logic [23:0] wr_data = 0;
   logic        d_a, d_b, d_c, i_a, i_b, i_c, f_a, f_b, f_c, md, mi, mf;
   logic        prev = 0;
   bit          busy_chk = 0;
   int          total = 0, bad = 0, cyc = 0, since = 100000, hi = 0;
   int          fd_cnt = 0, fd_cyc = 0, rise_cyc = 0, go_cyc = 0, rises = 0, busy_viol = 0;
   logic        exp_q[$];
   vec_t        tbl[3];

   always #5 clk = ~clk;

   rgbled_chain_ctrl #(.NumLeds(1)) u_a (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en && sel == 0), .wr_idx_i(wr_idx[0:0]),
      .wr_data_i(wr_data), .go_i(go && sel == 0), .continuous_i(cont && sel == 0),
      .idle_o(i_a), .frame_done_o(f_a), .dout_o(d_a));
   rgbled_chain_ctrl #(.NumLeds(2)) u_b (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en && sel == 1), .wr_idx_i(wr_idx[0:0]),
      .wr_data_i(wr_data), .go_i(go && sel == 1), .continuous_i(cont && sel == 1),
      .idle_o(i_b), .frame_done_o(f_b), .dout_o(d_b));
   rgbled_chain_ctrl #(.NumLeds(3)) u_c (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en && sel == 2), .wr_idx_i(wr_idx),
      .wr_data_i(wr_data), .go_i(go && sel == 2), .continuous_i(cont && sel == 2),
      .idle_o(i_c), .frame_done_o(f_c), .dout_o(d_c));

   assign md = sel == 0 ? d_a : sel == 1 ? d_b : d_c;
   assign mi = sel == 0 ? i_a : sel == 1 ? i_b : i_c;
   assign mf = sel == 0 ? f_a : sel == 1 ? f_b : f_c;

   function automatic void check(input string n, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", n, got, want);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic e;
      forever begin
         @(negedge clk);
         cyc++;
         since++;
         if (mf) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         if (busy_chk && mi) busy_viol++;
         if (md && !prev) begin
            rises++;
            if (since > 1000) rise_cyc = cyc;
            else check("bit_period", since, B);
            since = 0;
            hi = 1;
         end else if (md) begin
            hi++;
         end else if (prev) begin
            if (exp_q.size() == 0) check("extra_bit", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("bit_high", hi, e ? T1 : T0);
            end
         end
         prev = md;
      end
   endtask

   task automatic push_led(input logic [23:0] g);
      for (int i = 23; i >= 0; i--) exp_q.push_back(g[i]);
   endtask

   task automatic wr(input logic [1:0] i, input logic [23:0] v);
      wr_en = 1; wr_idx = i; wr_data = v;
      tick();
      wr_en = 0;
   endtask

   task automatic start();
      go = 1;
      go_cyc = cyc;
      tick();
      go = 0;
   endtask

   task automatic pulse_go();
      go = 1;
      tick();
      go = 0;
   endtask

   task automatic wait_fd(input string n, input int lim);
      int c0;
      c0 = fd_cnt;
      for (int k = 0; k < lim && fd_cnt == c0; k++) tick();
      check(n, fd_cnt - c0, 1);
   endtask

   task automatic frame_end(input string n, input int leds);
      wait_fd({n, "_fd"}, leds * 24 * B + R + 200);
      check({n, "_len"}, fd_cyc - rise_cyc + 1, leds * 24 * B + R);
      check({n, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      int f, r0, c0;
      tbl[0] = '{24'h00FF00, 24'hFF0000};
      tbl[1] = '{24'h123456, 24'h341256};
      tbl[2] = '{24'hA5C3F0, 24'hC3A5F0};
      fork monitor(); join_none
      repeat (3) tick();
      check("rst_dout", {d_a, d_b, d_c}, 0);
      check("rst_idle", {i_a, i_b, i_c}, 3'b111);
      check("rst_fd", {f_a, f_b, f_c}, 0);
      rst = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         check("idle_dout", {d_a, d_b, d_c}, 0);
         check("idle_o", {i_a, i_b, i_c}, 3'b111);
         check("idle_fd", {f_a, f_b, f_c}, 0);
      end
      // single-LED frames from the vector table
      sel = 0;
      foreach (tbl[v]) begin
         wr(0, tbl[v].rgb);
         push_led(tbl[v].grb);
         start();
         frame_end("tbl", 1);
         check("tbl_lat", rise_cyc - go_cyc, 2);
         tick();
         check("tbl_idle", mi, 1);
      end
      // two LEDs: write during transmission lands in the next frame
      sel = 1;
      wr(0, 24'h11AA22);
      push_led(24'hAA1122);
      push_led(24'h000000);
      start();
      repeat (300) tick();
      wr(1, 24'h0000FF);
      frame_end("dbuf1", 2);
      push_led(24'hAA1122);
      push_led(24'h0000FF);
      go = 1; wr_en = 1; wr_idx = 0; wr_data = 24'h00FF00; go_cyc = cyc;
      tick();
      go = 0; wr_en = 0;
      frame_end("dbuf2", 2);
      check("dbuf2_lat", rise_cyc - go_cyc, 2);
      // continuous mode: two back-to-back frames from a single go
      repeat (2) begin
         push_led(24'hFF0000);
         push_led(24'h0000FF);
      end
      cont = 1;
      c0 = fd_cnt;
      start();
      busy_chk = 1;
      wait_fd("cont_fd1", 48 * B + R + 200);
      check("cont_len1", fd_cyc - rise_cyc + 1, 48 * B + R);
      f = fd_cyc;
      tick();
      check("cont_restart", rise_cyc, f + 1);
      cont = 0;
      frame_end("cont2", 2);
      busy_chk = 0;
      check("cont_busy_idle", busy_viol, 0);
      check("cont_fd_count", fd_cnt - c0, 2);
      tick();
      check("cont_idle_end", mi, 1);
      // reset during the low phase of LED 1 bit 5
      push_led(24'hFF0000);
      push_led(24'h0000FF);
      start();
      repeat (29 * B + 50) tick();
      rst = 1;
      tick();
      check("midrst_dout", md, 0);
      check("midrst_idle", mi, 1);
      rst = 0;
      check("midrst_pending", exp_q.size(), 18);
      exp_q.delete();
      r0 = rises;
      c0 = fd_cnt;
      repeat (1100) tick();
      check("midrst_no_resume", rises - r0, 0);
      check("midrst_no_fd", fd_cnt - c0, 0);
      push_led(24'h000000);
      push_led(24'h000000);
      start();
      frame_end("midrst_zero", 2);
      // three LEDs: out-of-range write and go while busy are ignored
      sel = 2;
      wr(0, 24'h010203);
      wr(1, 24'h808080);
      wr(2, 24'hFF00FF);
      wr(3, 24'hFFFFFF);
      push_led(24'h020103);
      push_led(24'h808080);
      push_led(24'h00FFFF);
      start();
      repeat (500) tick();
      pulse_go();
      repeat (4000) tick();
      pulse_go();
      repeat (1500) tick();
      pulse_go();
      frame_end("three", 3);
      check("three_lat", rise_cyc - go_cyc, 2);
      r0 = rises;
      repeat (200) tick();
      check("three_no_requeue", rises - r0, 0);
      check("three_idle", mi, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rgbled_chain_ctrl.md
RGBLED_CHAIN_CTRL -- requirements
Module: rgbled_chain_ctrl

Interface
REQ-001 Parameter NumLeds, default 2: number of WS281x LEDs in the daisy chain; legal range 1..64.
REQ-002 Parameter T0HCycles, default 20: high time of a 0 bit, in clk_i cycles (0.4 us at 50 MHz).
REQ-003 Parameter T1HCycles, default 40: high time of a 1 bit, in clk_i cycles (0.8 us).
REQ-004 Parameter BitCycles, default 63: total bit period, in clk_i cycles (1.26 us); must exceed T1HCycles.
REQ-005 Parameter ResetCycles, default 4000: low latch gap after a frame, in clk_i cycles (80 us).
REQ-006 clk_i  in  1  system clock; the block uses one clock only.
REQ-007 rst_i  in  1  reset; synchronous, active-high.
REQ-008 wr_en_i  in  1  write strobe for one colour entry.
REQ-009 wr_idx_i  in  IdxW = max(1, clog2(NumLeds))  LED index; 0 = first LED on the chain.
REQ-010 wr_data_i  in  24  colour {R[7:0], G[7:0], B[7:0]}.
REQ-011 go_i  in  1  starts a frame; sampled only in IDLE.
REQ-012 continuous_i  in  1  when high, a new frame restarts automatically after each latch gap.
REQ-013 idle_o  out  1  high only in IDLE.
REQ-014 frame_done_o  out  1  one-cycle pulse at the end of each latch gap.
REQ-015 dout_o  out  1  serial data, active-high; any pad inversion happens at top level.

Function
REQ-016 The block shall hold a write buffer of NumLeds x 24 bits; wr_en_i shall update entry wr_idx_i on the next edge in every state.
REQ-017 A write with wr_idx_i >= NumLeds shall be ignored.
REQ-018 The block shall hold a display buffer of NumLeds x 24 bits; on each frame start the whole write buffer shall be copied into it in one cycle.
REQ-019 A write in the same cycle as the copy shall land in the write buffer only, and shall show in the next frame.
REQ-020 FSM states: IDLE, SEND_HIGH, SEND_LOW, LATCH.
REQ-021 IDLE with go_i=1: copy buffers, load LED 0 bit 23, enter SEND_HIGH; dout_o rises on the first cycle after go_i is sampled.
REQ-022 Transmit order per LED: G[7] down to G[0], then R[7:0], then B[7:0], MSB first; LEDs go from index 0 to NumLeds-1.
REQ-023 SEND_HIGH: dout_o=1 for T1HCycles if the bit is 1, else T0HCycles; then enter SEND_LOW.
REQ-024 SEND_LOW: dout_o=0 until the bit has lasted exactly BitCycles in total; then go to the next bit in SEND_HIGH.
REQ-025 After bit 0 of LED NumLeds-1, SEND_LOW shall enter LATCH.
REQ-026 LATCH: dout_o=0 for exactly ResetCycles cycles; frame_done_o shall pulse on the last LATCH cycle.
REQ-027 Leaving LATCH: if continuous_i=1, copy buffers and enter SEND_HIGH with no IDLE cycle; otherwise enter IDLE.
REQ-028 go_i outside IDLE shall be ignored; it is not queued.
REQ-029 Total frame length shall be NumLeds*24*BitCycles + ResetCycles cycles.
REQ-030 The bit-cycle counter shall be wide enough for max(BitCycles, ResetCycles) without wrap-around.

Reset
REQ-031 While rst_i is high at a clk_i edge: FSM to IDLE, dout_o=0, frame_done_o=0, idle_o=1, all counters 0, both buffers all-zero.
REQ-032 Reset asserted mid-bit or mid-latch shall force dout_o low on the next edge; no partial frame resumes afterwards.

Structure
REQ-033 Package rgbled_pkg shall hold the FSM state enum, the 24-bit colour typedef, and the default timing constants.
REQ-034 One sub-module, ws281x_bit_enc, shall time a single bit (inputs: start, bit value; outputs: dout, bit-done); the parent owns sequencing and the buffers.

Verification
REQ-035 Reset, then idle for 100 cycles -> dout_o=0, idle_o=1, frame_done_o never pulses.
REQ-036 NumLeds=1, write 0x00FF00 (R=0, G=0xFF, B=0), pulse go_i -> first 8 bits high 40 cycles each, next 16 high 20 cycles each, every bit 63 cycles; frame_done_o after 24*63+4000 cycles.
REQ-037 NumLeds=2, write idx1=0x0000FF during LED0 transmission, then a second go -> first frame sends old idx1 (0x000000), second frame sends B=0xFF.
REQ-038 continuous_i=1 with one go_i pulse -> frames back-to-back, one frame_done_o per frame, next dout_o rise on the cycle after the pulse, idle_o stays 0.
REQ-039 Assert rst_i during bit 5 of LED 1 -> dout_o=0 next cycle, state IDLE, display buffer read back as all-zero in the next frame.
REQ-040 NumLeds=3, write to wr_idx_i=3 -> no buffer entry changes; go_i pulsed while busy -> frame length unchanged.
